ga25_gfx_arbiter: RTL and testbench

- Round-robin arbiter that shares the single graphics-ROM SDRAM read channel between NUM_PORTS tile/sprite fetch requesters.
- Each requester raises an edge-triggered request with a word address. The block ORs in the GFX region base, serialises accesses to the SDRAM port, and returns 32-bit data with a one-cycle ready pulse.
- Includes a response watchdog so a lost sdr_rdy cannot hang video fetch.
- Everything runs in the clk domain.

---
 rtl/ga25_gfx_arbiter.sv | 167 ++++++++++++++++
 tb/tb_ga25_gfx_arbiter.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ga25_gfx_arbiter.sv
// ga25_gfx_arbiter: round-robin share of the GFX ROM SDRAM read channel.
// Optional per-port one-entry read cache: define GA25_GFX_ARB_CACHE_EN.
module ga25_gfx_arbiter #(
    parameter int          NUM_PORTS = 4,
    parameter int          ADDR_W    = 22,
    parameter logic [24:0] BASE_ADDR = 25'h0,
    parameter int          TIMEOUT   = 255
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [NUM_PORTS*ADDR_W-1:0] addr,
    output logic [NUM_PORTS*32-1:0]     data,
    output logic [NUM_PORTS-1:0]        rdy,
    output logic [24:0]                 sdr_addr,
    output logic                        sdr_req,
    input  logic [31:0]                 sdr_data,
    input  logic                        sdr_rdy,
    output logic                        busy,
    output logic                        timeout_err
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [9:0] WD_LAST = 10'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]           state;
    logic [NUM_PORTS-1:0] req_d;
    logic [NUM_PORTS-1:0] pend;
    logic [NUM_PORTS-1:0] edge_v;
    logic [24:0]          paddr    [NUM_PORTS];
    logic [24:0]          addr_ext [NUM_PORTS];
    logic [31:0]          dreg     [NUM_PORTS];
    logic [PW-1:0]        ptr;
    logic [PW-1:0]        gnt;
    logic [PW-1:0]        sel;
    logic [PW:0]          cand;
    logic                 sel_v;
    logic [9:0]           wdog;
    logic                 hit;
    logic [31:0]          hit_data;

    assign edge_v = req & ~req_d;
    assign busy   = (state != S_IDLE);

    // Zero-extend each requester address to the 25-bit SDRAM space
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            addr_ext[i] = '0;
            addr_ext[i][ADDR_W-1:0] = addr[i*ADDR_W +: ADDR_W];
        end
    end

    // Round-robin pick: first pending port after the last grant
    always_comb begin
        sel_v = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = {1'b0, ptr} + (PW+1)'(k);
            if (cand >= (PW+1)'(NUM_PORTS))
                cand = cand - (PW+1)'(NUM_PORTS);
            if (!sel_v && pend[cand[PW-1:0]]) begin
                sel_v = 1'b1;
                sel   = cand[PW-1:0];
            end
        end
    end

`ifdef GA25_GFX_ARB_CACHE_EN
    logic [24:0]          ctag [NUM_PORTS];
    logic [31:0]          cdat [NUM_PORTS];
    logic [NUM_PORTS-1:0] cval;

    assign hit      = cval[sel] && (ctag[sel] == paddr[sel]);
    assign hit_data = cdat[sel];

    // Real SDRAM completions refill the granted port's entry
    always_ff @(posedge clk) begin
        if (reset) begin
            cval <= '0;
        end else if (state == S_WAIT && sdr_rdy) begin
            cval[gnt] <= 1'b1;
            ctag[gnt] <= sdr_addr;
            cdat[gnt] <= sdr_data;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    // Request capture, grant FSM, watchdog and response delivery
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            req_d       <= '0;
            pend        <= '0;
            rdy         <= '0;
            sdr_req     <= 1'b0;
            sdr_addr    <= '0;
            timeout_err <= 1'b0;
            ptr         <= PW'(NUM_PORTS - 1);
            gnt         <= '0;
            wdog        <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                paddr[i] <= '0;
                dreg[i]  <= '0;
            end
        end else begin
            req_d   <= req;
            rdy     <= '0;
            sdr_req <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (sel_v) begin
                        pend[sel] <= 1'b0;
                        ptr       <= sel;
                        if (hit) begin
                            rdy[sel]  <= 1'b1;
                            dreg[sel] <= hit_data;
                        end else begin
                            sdr_addr <= paddr[sel];
                            sdr_req  <= 1'b1;
                            gnt      <= sel;
                            state    <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    wdog  <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (sdr_rdy) begin
                        dreg[gnt] <= sdr_data;
                        rdy[gnt]  <= 1'b1;
                        state     <= S_IDLE;
                    end else if (wdog == WD_LAST) begin
                        dreg[gnt]   <= 32'hFFFF_FFFF;
                        rdy[gnt]    <= 1'b1;
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        wdog <= wdog + 10'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
            // A fresh edge wins over a same-cycle grant clear
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (edge_v[i]) begin
                    pend[i]  <= 1'b1;
                    paddr[i] <= BASE_ADDR | addr_ext[i];
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_out
        assign data[i*32 +: 32] = dreg[i];
    end

endmodule

// File: tb/tb_ga25_gfx_arbiter.sv
// tb_ga25_gfx_arbiter: directed scenarios plus random traffic, checked
// every cycle against a transaction-level model of the arbiter.
module tb_ga25_gfx_arbiter;

    localparam int          NP   = 4;
    localparam int          AW   = 22;
    localparam int          TO   = 16;
    localparam logic [24:0] BASE = 25'h100_0000;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NP-1:0]     req = '0;
    logic [NP*AW-1:0]  addr = '0;
    logic [NP*32-1:0]  data;
    logic [NP-1:0]     rdy;
    logic [24:0]       sdr_addr;
    logic              sdr_req;
    logic [31:0]       sdr_data = '0;
    logic              sdr_rdy = 1'b0;
    logic              busy;
    logic              timeout_err;

    int total = 0;
    int bad   = 0;
    int nprint = 0;

    ga25_gfx_arbiter #(
        .NUM_PORTS(NP),
        .ADDR_W(AW),
        .BASE_ADDR(BASE),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .addr(addr),
        .data(data),
        .rdy(rdy),
        .sdr_addr(sdr_addr),
        .sdr_req(sdr_req),
        .sdr_data(sdr_data),
        .sdr_rdy(sdr_rdy),
        .busy(busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // SDRAM responder: reply rsp_delay cycles after each sdr_req
    int          rsp_delay = 0;
    bit          rsp_rand = 1'b0;
    logic [31:0] rsp_val = '0;
    int          cd = 0;
    always @(negedge clk) begin
        sdr_rdy = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) sdr_rdy = 1'b1;
        end
        if (sdr_req === 1'b1 && rsp_delay > 0) begin
            cd = rsp_delay;
            sdr_data = rsp_rand ? 32'($urandom) : rsp_val;
        end
    end

    // Model: a set of pending reads, one outstanding read with an age,
    // and a round-robin scan over ports after the last one served.
    bit          m_started = 1'b0;
    bit          m_pend  [NP];
    logic [24:0] m_paddr [NP];
    logic [NP-1:0] m_prev;
    int          m_last;
    int          m_cur;
    int          m_age;
    bit          m_out;
    logic [NP-1:0] e_rdy;
    logic [31:0] e_data [NP];
    logic        e_sreq;
    logic [24:0] e_saddr;
    logic        e_terr;
    int          m_glog[$];
`ifdef GA25_GFX_ARB_CACHE_EN
    bit          m_cv [NP];
    logic [24:0] m_ct [NP];
    logic [31:0] m_cd [NP];
`endif

    always @(posedge clk) begin : model
        int g;
        m_started = 1'b1;
        if (reset) begin
            for (int i = 0; i < NP; i++) begin
                m_pend[i] = 1'b0;
                m_paddr[i] = '0;
                e_data[i] = '0;
`ifdef GA25_GFX_ARB_CACHE_EN
                m_cv[i] = 1'b0;
`endif
            end
            m_prev = '0;
            m_last = NP - 1;
            m_cur = 0;
            m_age = 0;
            m_out = 1'b0;
            e_rdy = '0;
            e_sreq = 1'b0;
            e_saddr = '0;
            e_terr = 1'b0;
        end else begin
            e_rdy = '0;
            e_sreq = 1'b0;
            if (m_out) begin
                if (m_age == 0) begin
                    m_age = 1;
                end else if (sdr_rdy) begin
                    e_data[m_cur] = sdr_data;
                    e_rdy[m_cur] = 1'b1;
                    m_out = 1'b0;
`ifdef GA25_GFX_ARB_CACHE_EN
                    m_cv[m_cur] = 1'b1;
                    m_ct[m_cur] = e_saddr;
                    m_cd[m_cur] = sdr_data;
`endif
                end else if (m_age == TO) begin
                    e_data[m_cur] = 32'hFFFF_FFFF;
                    e_rdy[m_cur] = 1'b1;
                    e_terr = 1'b1;
                    m_out = 1'b0;
                end else begin
                    m_age++;
                end
            end else begin
                g = -1;
                for (int j = 1; j <= NP; j++)
                    if (g < 0 && m_pend[(m_last + j) % NP]) g = (m_last + j) % NP;
                if (g >= 0) begin
                    m_pend[g] = 1'b0;
                    m_last = g;
`ifdef GA25_GFX_ARB_CACHE_EN
                    if (m_cv[g] && m_ct[g] == m_paddr[g]) begin
                        e_rdy[g] = 1'b1;
                        e_data[g] = m_cd[g];
                    end else
`endif
                    begin
                        e_saddr = m_paddr[g];
                        e_sreq = 1'b1;
                        m_out = 1'b1;
                        m_age = 0;
                        m_cur = g;
                        m_glog.push_back(g);
                    end
                end
            end
            for (int i = 0; i < NP; i++)
                if (req[i] && !m_prev[i]) begin
                    m_pend[i] = 1'b1;
                    m_paddr[i] = BASE | {3'b000, addr[i*AW +: AW]};
                end
            m_prev = req;
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin : cmp
        bit ok;
        if (m_started) begin
            ok = (rdy === e_rdy) && (sdr_req === e_sreq) &&
                 (sdr_addr === e_saddr) && (busy === m_out) &&
                 (timeout_err === e_terr);
            for (int i = 0; i < NP; i++)
                if (data[i*32 +: 32] !== e_data[i]) ok = 1'b0;
            total++;
            if (!ok) begin
                bad++;
                if (nprint < 20)
                    $display("FAIL model t=%0t got rdy=%b sreq=%b sa=%h busy=%b terr=%b d=%h want rdy=%b sreq=%b sa=%h busy=%b terr=%b d=%h_%h_%h_%h",
                             $time, rdy, sdr_req, sdr_addr, busy, timeout_err, data,
                             e_rdy, e_sreq, e_saddr, m_out, e_terr,
                             e_data[3], e_data[2], e_data[1], e_data[0]);
                nprint++;
            end
        end
    end

    // DUT grant log, port recovered from address bits [9:8]
    int d_glog[$];
    always @(negedge clk)
        if (m_started && sdr_req === 1'b1) d_glog.push_back(int'(sdr_addr[9:8]));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_rdy(input int p, input int maxc, output int cyc);
        cyc = -1;
        for (int c = 1; c <= maxc; c++) begin
            @(negedge clk);
            if (rdy[p] === 1'b1) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic wait_sreq(input int maxc, output int cyc);
        cyc = -1;
        for (int c = 1; c <= maxc; c++) begin
            @(negedge clk);
            if (sdr_req === 1'b1) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic idle_count(input int n, output int nr, output int ns);
        nr = 0;
        ns = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            nr += $countones(rdy);
            if (sdr_req === 1'b1) ns++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin : stim
        int c, nr, ns, ds, ms;
        bit rearm;

        // Reset state
        rsp_delay = 5;
        rsp_val = 32'hDEAD_BEEF;
        do_reset();
        chk("rst_rdy", rdy, 0);
        chk("rst_sreq", sdr_req, 0);
        chk("rst_saddr", sdr_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_terr", timeout_err, 0);
        chk("rst_data", data, 0);

        // Single request on port 2
        addr[2*AW +: AW] = 22'h001234;
        req[2] = 1'b1;
        @(negedge clk);
        chk("single_no_sreq_n1", sdr_req, 0);
        @(negedge clk);
        chk("single_sreq_n2", sdr_req, 1);
        chk("single_saddr", sdr_addr, 25'h100_1234);
        wait_rdy(2, 30, c);
        chk("single_rdy_lat", c, 6);
        chk("single_data", data[2*32 +: 32], 32'hDEAD_BEEF);
        chk("single_rdy_bits", rdy, 4'b0100);
        @(negedge clk);
        chk("single_rdy_once", rdy, 0);
        req = '0;
        repeat (3) @(negedge clk);

        // All ports request, held through reset
        rsp_delay = 3;
        rsp_rand = 1'b1;
        reset = 1'b1;
        for (int i = 0; i < NP; i++) addr[i*AW +: AW] = 22'(i * 256 + i + 1);
        req = '1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ds = d_glog.size();
        ms = m_glog.size();
        nr = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            nr += $countones(rdy);
            if (nr >= 4) break;
        end
        chk("all4_nrdy", nr, 4);
        if (d_glog.size() >= ds + 4 && m_glog.size() >= ms + 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("all4_dut_grant%0d", i), d_glog[ds+i], i);
                chk($sformatf("all4_mdl_grant%0d", i), m_glog[ms+i], i);
            end
        end else begin
            chk("all4_grant_count", d_glog.size() - ds, 4);
        end
        req = '0;
        repeat (5) @(negedge clk);

        // Fairness: port 0 keeps re-requesting, 1 and 3 stay pending
        do_reset();
        rsp_delay = 2;
        addr[0*AW +: AW] = 22'h000011;
        addr[1*AW +: AW] = 22'h000122;
        addr[3*AW +: AW] = 22'h000333;
        ds = d_glog.size();
        ms = m_glog.size();
        req = 4'b1011;
        rearm = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (rearm) begin
                req[0] = 1'b1;
                rearm = 1'b0;
            end else if (rdy[0] === 1'b1) begin
                req[0] = 1'b0;
                rearm = 1'b1;
            end
            if (d_glog.size() >= ds + 4) break;
        end
        if (d_glog.size() >= ds + 4 && m_glog.size() >= ms + 4) begin
            chk("fair_dut0", d_glog[ds+0], 0);
            chk("fair_dut1", d_glog[ds+1], 1);
            chk("fair_dut2", d_glog[ds+2], 3);
            chk("fair_dut3", d_glog[ds+3], 0);
            chk("fair_mdl2", m_glog[ms+2], 3);
        end else begin
            chk("fair_grant_count", d_glog.size() - ds, 4);
        end
        req = '0;
        repeat (60) @(negedge clk);

        // Watchdog timeout, late reply dropped, then a normal read
        do_reset();
        rsp_delay = 20;
        rsp_rand = 1'b0;
        rsp_val = 32'h0BAD_0BAD;
        addr[1*AW +: AW] = 22'h000123;
        req[1] = 1'b1;
        wait_sreq(10, c);
        chk("to_sreq_lat", c, 2);
        wait_rdy(1, 40, c);
        chk("to_rdy_lat", c, 17);
        chk("to_data", data[1*32 +: 32], 32'hFFFF_FFFF);
        chk("to_err", timeout_err, 1);
        req[1] = 1'b0;
        idle_count(10, nr, ns);
        chk("to_late_ignored", nr, 0);
        rsp_delay = 4;
        rsp_val = 32'h1234_5678;
        addr[1*AW +: AW] = 22'h000155;
        req[1] = 1'b1;
        wait_rdy(1, 30, c);
        chk("to_next_lat", c, 7);
        chk("to_next_data", data[1*32 +: 32], 32'h1234_5678);
        chk("to_err_sticky", timeout_err, 1);
        req = '0;
        repeat (3) @(negedge clk);

        // Reset while waiting on SDRAM
        do_reset();
        rsp_delay = 10;
        addr[3*AW +: AW] = 22'h000301;
        req[3] = 1'b1;
        wait_sreq(10, c);
        chk("rw_sreq_lat", c, 2);
        repeat (3) @(negedge clk);
        chk("rw_busy", busy, 1);
        req = '0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rw_busy0", busy, 0);
        chk("rw_saddr0", sdr_addr, 0);
        chk("rw_terr0", timeout_err, 0);
        chk("rw_data0", data, 0);
        idle_count(15, nr, ns);
        chk("rw_no_rdy", nr, 0);
        chk("rw_no_sreq", ns, 0);

`ifdef GA25_GFX_ARB_CACHE_EN
        // Cache: repeat address hits, new address misses
        do_reset();
        rsp_delay = 3;
        rsp_val = 32'hCAFE_0001;
        addr[1*AW +: AW] = 22'h000010;
        req[1] = 1'b1;
        wait_rdy(1, 30, c);
        chk("cache_first_data", data[1*32 +: 32], 32'hCAFE_0001);
        req[1] = 1'b0;
        @(negedge clk);
        rsp_val = 32'h5555_AAAA;
        ds = d_glog.size();
        req[1] = 1'b1;
        wait_rdy(1, 10, c);
        chk("cache_hit_lat", c, 2);
        chk("cache_hit_data", data[1*32 +: 32], 32'hCAFE_0001);
        chk("cache_hit_nosreq", d_glog.size() - ds, 0);
        req[1] = 1'b0;
        @(negedge clk);
        addr[1*AW +: AW] = 22'h000011;
        req[1] = 1'b1;
        wait_sreq(10, c);
        chk("cache_miss_sreq", c, 2);
        wait_rdy(1, 30, c);
        chk("cache_miss_data", data[1*32 +: 32], 32'h5555_AAAA);
        req = '0;
        repeat (3) @(negedge clk);
`endif

        // Random traffic
        rsp_rand = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 399) == 0);
            for (int i = 0; i < NP; i++)
                if ($urandom_range(0, 5) == 0) begin
                    req[i] = ~req[i];
                    addr[i*AW +: AW] = 22'($urandom_range(0, 3) + i * 256);
                end
            rsp_delay = $urandom_range(1, 22);
        end
        reset = 1'b0;
        req = '0;
        repeat (40) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
